freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/freq_meter_sync_edge_det.sv | 33 +++
 rtl/freq_meter.sv | 116 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and default sizing for the frequency meter
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    // 2^25 cycles matches the 25-bit divider that produces the 1 Hz system tick.
    localparam int DEFAULT_GATE_CYCLES = 33554432;
    localparam int DEFAULT_COUNT_W     = 16;
    localparam int GATE_CNT_W          = 26;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// rtl/freq_meter_sync_edge_det.sv - two-flop synchronizer plus rising-edge detect
module sync_edge_det (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts signal_in rising edges over back-to-back fixed-length gate windows
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int COUNT_W     = DEFAULT_COUNT_W
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               signal_in,
    output logic [COUNT_W-1:0] freq_count,
    output logic               valid,
    output logic               overflow,
    output logic               busy
);

    localparam logic [GATE_CNT_W-1:0] GATE_LAST = GATE_CNT_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]    COUNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic                    sat_q, sat_d;
    logic [COUNT_W-1:0]      freq_count_q, freq_count_d;
    logic                    overflow_q, overflow_d;
    logic                    valid_q, valid_d;
    logic                    rise;
    logic [COUNT_W-1:0]      edge_cnt_next;
    logic                    sat_next;

    sync_edge_det u_sync_edge_det (
        .clock_in (clock_in),
        .reset    (reset),
        .d        (signal_in),
        .rise     (rise)
    );

    always_comb begin
        state_d       = state_q;
        gate_cnt_d    = gate_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        sat_d         = sat_q;
        freq_count_d  = freq_count_q;
        overflow_d    = overflow_q;
        valid_d       = 1'b0;
        edge_cnt_next = edge_cnt_q;
        sat_next      = sat_q;

        // Saturating count including an edge seen this cycle, so a close-cycle edge is kept.
        if (rise) begin
            if (edge_cnt_q == COUNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (enable) begin
                    state_d = ST_GATE;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    freq_count_d = edge_cnt_next;
                    overflow_d   = sat_next;
                    valid_d      = 1'b1;
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    sat_d        = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                    edge_cnt_d = edge_cnt_next;
                    sat_d      = sat_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_count_q <= freq_count_d;
            overflow_q   <= overflow_d;
            valid_q      <= valid_d;
        end
    end

    assign freq_count = freq_count_q;
    assign overflow   = overflow_q;
    assign valid      = valid_q;
    assign busy       = (state_q == ST_GATE);

endmodule
